sample_framer: RTL and testbench

SAMPLE_FRAMER -- requirements
Module: sample_framer

---
 rtl/sample_framer.sv | 149 ++++++++++++++
 tb/tb_sample_framer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_framer.sv
// rtl/sample_framer.sv - gathers strobed antenna samples into frames for the FFT
//
// Optional feature: define SAMPLE_FRAMER_DROP_CNT_EN to count strobes dropped
// while a frame is draining. Left undefined, dropped_cnt is tied to 0.
//
// Ports:
//   clk, reset_n          single clock, asynchronous active-low reset
//   sample_stb, sink      one-cycle sample strobe and signed sample value
//   start                 request RUNS frames (ignored while busy)
//   src_data/valid/ready  frame output stream with ready/valid handshake
//   src_sop, src_eop      first / last sample of a frame
//   run_idx               index of the current frame, 0..RUNS-1
//   busy                  high whenever the FSM is not idle
//   dropped_cnt           saturating count of strobes dropped during drain
module sample_framer #(
   parameter int SINK_WIDTH = 14,
   parameter int FFT_DEPTH  = 11,
   parameter int RUNS       = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  sample_stb,
   input  logic [SINK_WIDTH-1:0] sink,
   input  logic                  start,
   input  logic                  src_ready,
   output logic [SINK_WIDTH-1:0] src_data,
   output logic                  src_valid,
   output logic                  src_sop,
   output logic                  src_eop,
   output logic [7:0]            run_idx,
   output logic                  busy,
   output logic [15:0]           dropped_cnt
);

   localparam int                   DEPTH     = 1 << FFT_DEPTH;
   localparam logic [FFT_DEPTH-1:0] LAST_ADDR = '1;
   localparam logic [7:0]           LAST_RUN  = 8'(RUNS - 1);

   typedef enum logic [1:0] {IDLE, FILL, DRAIN, NEXT} state_t;

   state_t                 state, state_nxt;
   logic [FFT_DEPTH-1:0]   waddr, raddr;
   logic                   rd_done;
   logic [SINK_WIDTH-1:0]  mem [DEPTH];
   logic [SINK_WIDTH-1:0]  mem_q;
   logic                   q_valid, q_sop, q_eop;
   logic                   wr_en, rd_en, load_out, xfer;

   assign busy     = (state != IDLE);
   assign xfer     = src_valid && src_ready;
   // The output register takes the RAM word when it is empty or being emptied.
   assign load_out = q_valid && (!src_valid || src_ready);
   // A new read is issued only when the RAM output word will be free next cycle,
   // so a stalled sample is never overwritten and ready=1 gives one per clock.
   assign rd_en    = (state == DRAIN) && !rd_done && (!q_valid || load_out);

   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = FILL;
         FILL:  if (sample_stb) begin
                   wr_en = 1'b1;
                   if (waddr == LAST_ADDR) state_nxt = DRAIN;
                end
         DRAIN: if (xfer && src_eop) state_nxt = NEXT;
         NEXT:  state_nxt = (run_idx == LAST_RUN) ? IDLE : FILL;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         waddr     <= '0;
         raddr     <= '0;
         rd_done   <= 1'b0;
         run_idx   <= '0;
         q_valid   <= 1'b0;
         q_sop     <= 1'b0;
         q_eop     <= 1'b0;
         src_valid <= 1'b0;
         src_sop   <= 1'b0;
         src_eop   <= 1'b0;
         src_data  <= '0;
      end else begin
         if (state == IDLE && start) begin
            waddr   <= '0;
            run_idx <= '0;
         end
         if (wr_en) waddr <= waddr + 1'b1;
         if (state == NEXT && run_idx != LAST_RUN) begin
            run_idx <= run_idx + 8'd1;
            waddr   <= '0;
         end
         // Read pointer is rearmed for every frame while filling.
         if (state == FILL) begin
            raddr   <= '0;
            rd_done <= 1'b0;
         end
         if (rd_en) begin
            raddr <= raddr + 1'b1;
            q_sop <= (raddr == '0);
            q_eop <= (raddr == LAST_ADDR);
            if (raddr == LAST_ADDR) rd_done <= 1'b1;
         end
         if (rd_en)         q_valid <= 1'b1;
         else if (load_out) q_valid <= 1'b0;
         if (load_out) begin
            src_valid <= 1'b1;
            src_data  <= mem_q;
            src_sop   <= q_sop;
            src_eop   <= q_eop;
         end else if (xfer) begin
            src_valid <= 1'b0;
            src_sop   <= 1'b0;
            src_eop   <= 1'b0;
         end
      end
   end

   // Frame buffer: no reset so it maps onto block RAM with a registered read.
   always_ff @(posedge clk) begin
      if (wr_en) mem[waddr] <= sink;
      if (rd_en) mem_q <= mem[raddr];
   end

`ifdef SAMPLE_FRAMER_DROP_CNT_EN
   logic        drop;
   logic [15:0] drop_cnt;

   assign drop = sample_stb && (state == DRAIN || state == NEXT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                              drop_cnt <= '0;
      else if (state == IDLE && start)           drop_cnt <= '0;
      else if (drop && drop_cnt != 16'hFFFF)     drop_cnt <= drop_cnt + 16'd1;
   end

   assign dropped_cnt = drop_cnt;
`else
   assign dropped_cnt = '0;
`endif

endmodule

// File: tb/tb_sample_framer.sv
// tb/tb_sample_framer.sv - randomized self-checking bench for sample_framer
module tb_sample_framer;

   localparam int W = 14, D = 3, R = 2, N = 8;
   localparam int P_IDLE = 0, P_FILL = 1, P_WAIT = 2, P_NEXT = 3;

   logic          clk, reset_n, sample_stb, start, src_ready;
   logic [W-1:0]  sink, src_data;
   logic          src_valid, src_sop, src_eop, busy;
   logic [7:0]    run_idx;
   logic [15:0]   dropped_cnt;

   int checks = 0, errors = 0;

   // Reference model: frame collection / drain / gap phases of the framer.
   int            m_phase, m_fc, m_idx, m_run, m_drops, m_edges, m_first, m_refill;
   bit            m_rall;
   logic [W-1:0]  m_frame [N];
   logic [W-1:0]  xq [$];
   logic [W-1:0]  mq [$];
   logic [7:0]    xrun [$];
   int            strobe_num;

   sample_framer #(.SINK_WIDTH(W), .FFT_DEPTH(D), .RUNS(R)) dut (
      .clk(clk), .reset_n(reset_n), .sample_stb(sample_stb), .sink(sink),
      .start(start), .src_ready(src_ready), .src_data(src_data),
      .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
      .run_idx(run_idx), .busy(busy), .dropped_cnt(dropped_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int exp_drop();
`ifdef SAMPLE_FRAMER_DROP_CNT_EN
      return m_drops;
`else
      return 0;
`endif
   endfunction

   // Monitor: at each falling edge check outputs against the model, then
   // advance the model with the inputs about to be clocked in.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            m_phase = P_IDLE; m_fc = 0; m_idx = 0; m_run = 0; m_drops = 0;
            checks++;
            if ({src_valid, src_sop, src_eop, src_data, busy, run_idx, dropped_cnt} !== '0) begin
               errors++;
               $display("FAIL reset_outputs: valid=%b sop=%b eop=%b data=%0h busy=%b run=%0d drop=%0d required all 0",
                        src_valid, src_sop, src_eop, src_data, busy, run_idx, dropped_cnt);
            end
         end else begin
            checks++;
            if (busy !== (m_phase != P_IDLE)) begin
               errors++; $display("FAIL busy: got %b expected %b", busy, m_phase != P_IDLE);
            end
            checks++;
            if (run_idx !== 8'(m_run)) begin
               errors++; $display("FAIL run_idx: got %0d expected %0d", run_idx, m_run);
            end
            checks++;
            if (dropped_cnt !== 16'(exp_drop())) begin
               errors++; $display("FAIL dropped_cnt: got %0d expected %0d", dropped_cnt, exp_drop());
            end
            checks++;
            if (m_phase == P_WAIT && src_valid === 1'b1) begin
               if (src_data !== m_frame[m_idx] || src_sop !== (m_idx == 0) || src_eop !== (m_idx == N-1)) begin
                  errors++;
                  $display("FAIL sample[%0d]: got data=%0h sop=%b eop=%b expected data=%0h sop=%b eop=%b",
                           m_idx, src_data, src_sop, src_eop, m_frame[m_idx], m_idx == 0, m_idx == N-1);
               end
            end else if (m_phase != P_WAIT && src_valid !== 1'b0) begin
               errors++; $display("FAIL valid_outside_drain: got %b expected 0 (phase %0d)", src_valid, m_phase);
            end
            case (m_phase)
               P_IDLE: if (start) begin
                  m_phase = P_FILL; m_fc = 0; m_run = 0; m_drops = 0;
               end
               P_FILL: if (sample_stb) begin
                  m_frame[m_fc] = sink; mq.push_back(sink); m_fc++;
                  if (m_fc == N) begin
                     m_phase = P_WAIT; m_idx = 0; m_edges = 0; m_first = -1; m_rall = 1;
                  end
               end
               P_WAIT: begin
                  m_edges++;
                  if (src_valid && m_first < 0) begin
                     m_first = m_edges - 1;
                     checks++;
                     if (m_first != 2) begin
                        errors++; $display("FAIL first_latency: got %0d cycles expected 2", m_first);
                     end
                  end
                  if (src_valid && !src_ready) m_rall = 0;
                  if (src_valid && src_ready) begin
                     xq.push_back(src_data); xrun.push_back(run_idx); m_idx++;
                     if (m_idx == N) begin
                        if (m_rall) begin
                           checks++;
                           if (m_edges != N + 2) begin
                              errors++; $display("FAIL drain_throughput: got %0d cycles expected %0d", m_edges, N + 2);
                           end
                        end
                        m_phase = P_NEXT;
                     end
                  end
                  if (sample_stb && m_drops < 65535) m_drops++;
               end
               default: begin
                  if (sample_stb && m_drops < 65535) m_drops++;
                  if (m_run == R - 1) m_phase = P_IDLE;
                  else begin
                     m_run++; m_fc = 0; m_refill = m_drops; m_phase = P_FILL;
                  end
               end
            endcase
         end
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic clear_run();
      xq.delete(); mq.delete(); xrun.delete(); strobe_num = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1; sample_stb = 1'b0; cyc(); start = 1'b0;
   endtask

   // period 0 = random strobes; rmode 1 = ready high, 2 = random ready.
   task automatic drive(input int period, input int rmode, input bit rsink, input int p1, input int p2);
      int c;
      for (c = 0; c < 3000; c++) begin
         if (m_phase == P_IDLE) break;
         sample_stb = (period == 0) ? ($urandom_range(0, 2) == 0) : (c % period == 0);
         if (sample_stb) begin
            strobe_num++;
            sink = rsink ? W'($urandom) : W'(strobe_num);
         end
         src_ready = (rmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
         start = (c == p1 || c == p2);
         cyc();
         if (c == p1 || c == p2) begin
            checks++;
            if (busy !== 1'b1 || run_idx !== 8'(m_run)) begin
               errors++; $display("FAIL busy_start: busy=%b run_idx=%0d expected busy=1 run_idx=%0d", busy, run_idx, m_run);
            end
         end
      end
      sample_stb = 1'b0; start = 1'b0; src_ready = 1'b1;
      checks++;
      if (m_phase != P_IDLE) begin
         errors++; $display("FAIL timeout: sequence did not finish, phase %0d expected %0d", m_phase, P_IDLE);
      end
   endtask

   task automatic check_queues(input string name);
      checks++;
      if (xq.size() != N * R || mq.size() != N * R) begin
         errors++; $display("FAIL %s_count: got %0d transfers expected %0d", name, xq.size(), N * R);
      end
      for (int i = 0; i < xq.size() && i < mq.size(); i++) begin
         checks++;
         if (xq[i] !== mq[i]) begin
            errors++; $display("FAIL %s_data[%0d]: got %0h expected %0h", name, i, xq[i], mq[i]);
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; sample_stb = 1'b0; sink = '0; src_ready = 1'b1;
      repeat (3) cyc();
      checks++;
      if ({src_valid, src_sop, src_eop, src_data, busy, run_idx, dropped_cnt} !== '0) begin
         errors++; $display("FAIL test_reset: outputs not zero in reset, valid=%b busy=%b data=%0h expected 0", src_valid, busy, src_data);
      end
      reset_n = 1'b1;
      repeat (3) cyc();
      checks++;
      if (busy !== 1'b0 || src_valid !== 1'b0) begin
         errors++; $display("FAIL test_reset_release: busy=%b valid=%b expected 0 0", busy, src_valid);
      end
   endtask

   task automatic test_frames();
      clear_run(); pulse_start();
      drive(3, 1, 0, -1, -1);
      checks++;
      if (xq.size() != 16) begin
         errors++; $display("FAIL frames_count: got %0d expected 16", xq.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (xq[i] !== W'(i + 1) || xq[8+i] !== W'(9 + m_refill + i)) begin
               errors++; $display("FAIL frames_value[%0d]: got %0d/%0d expected %0d/%0d", i, xq[i], xq[8+i], i + 1, 9 + m_refill + i);
            end
         end
         checks++;
         if (xrun[0] !== 8'd0 || xrun[8] !== 8'd1) begin
            errors++; $display("FAIL frames_run_idx: got %0d,%0d expected 0,1", xrun[0], xrun[8]);
         end
      end
   endtask

   task automatic test_backpressure();
      int c = 0, ones = 0;
      clear_run(); pulse_start();
      while (src_valid !== 1'b1 && c < 200) begin
         sample_stb = (c % 3 == 0);
         if (sample_stb) begin strobe_num++; sink = W'(strobe_num); end
         src_ready = 1'b0; cyc(); c++;
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (src_valid !== 1'b1 || src_data !== W'(1) || src_sop !== 1'b1 || src_eop !== 1'b0) begin
            errors++; $display("FAIL backpressure_hold[%0d]: valid=%b data=%0d sop=%b expected 1 1 1", i, src_valid, src_data, src_sop);
         end
         sample_stb = (c % 3 == 0);
         if (sample_stb) begin strobe_num++; sink = W'(strobe_num); end
         src_ready = 1'b0; cyc(); c++;
      end
      drive(3, 1, 0, -1, -1);
      foreach (xq[i]) if (xq[i] === W'(1)) ones++;
      checks++;
      if (ones != 1 || xq.size() == 0 || xq[0] !== W'(1)) begin
         errors++; $display("FAIL backpressure_once: sample 1 transferred %0d times expected 1", ones);
      end
      check_queues("backpressure");
   endtask

   task automatic test_start_with_strobe();
      int hits = 0;
      clear_run();
      start = 1'b1; sample_stb = 1'b1; sink = 14'h2AAA; cyc();
      start = 1'b0; sample_stb = 1'b0;
      drive(3, 1, 0, -1, -1);
      foreach (xq[i]) if (xq[i] === 14'h2AAA) hits++;
      checks++;
      if (hits != 0 || xq.size() == 0 || xq[0] !== W'(1)) begin
         errors++; $display("FAIL start_strobe: first=%0h stale_hits=%0d expected first=1 hits=0", xq.size() ? xq[0] : '0, hits);
      end
      check_queues("start_strobe");
   endtask

   task automatic test_mid_reset();
      int c = 0;
      clear_run(); pulse_start();
      while (m_fc < 4 && c < 100) begin
         sample_stb = (c % 3 == 0);
         if (sample_stb) begin strobe_num++; sink = W'(strobe_num); end
         cyc(); c++;
      end
      sample_stb = 1'b0;
      reset_n = 1'b0; #1;
      checks++;
      if ({src_valid, src_sop, src_eop, src_data, busy, run_idx, dropped_cnt} !== '0) begin
         errors++; $display("FAIL mid_reset_async: busy=%b valid=%b run=%0d expected 0", busy, src_valid, run_idx);
      end
      cyc(); reset_n = 1'b1; cyc(); cyc();
      checks++;
      if (busy !== 1'b0 || src_valid !== 1'b0) begin
         errors++; $display("FAIL mid_reset_idle: busy=%b valid=%b expected 0 0", busy, src_valid);
      end
      clear_run(); strobe_num = 100; pulse_start();
      drive(3, 1, 0, -1, -1);
      for (int i = 0; i < 8 && i < xq.size(); i++) begin
         checks++;
         if (xq[i] !== W'(101 + i)) begin
            errors++; $display("FAIL mid_reset_frame[%0d]: got %0d expected %0d", i, xq[i], 101 + i);
         end
      end
      check_queues("mid_reset");
   endtask

   task automatic test_drop_count();
      int c = 0;
      clear_run(); pulse_start();
      while (m_phase != P_WAIT && c < 200) begin
         sample_stb = (c % 3 == 0);
         if (sample_stb) begin strobe_num++; sink = W'(strobe_num); end
         src_ready = 1'b0; cyc(); c++;
      end
      for (int i = 0; i < 20; i++) begin
         sample_stb = 1'b1; strobe_num++; sink = W'(strobe_num); src_ready = 1'b0; cyc();
      end
      checks++;
`ifdef SAMPLE_FRAMER_DROP_CNT_EN
      if (dropped_cnt !== 16'd20) begin
         errors++; $display("FAIL drop_count: got %0d expected 20", dropped_cnt);
      end
`else
      if (dropped_cnt !== 16'd0) begin
         errors++; $display("FAIL drop_count: got %0d expected 0", dropped_cnt);
      end
`endif
      drive(1, 1, 0, -1, -1);
      check_queues("drop_count");
   endtask

   task automatic test_start_while_busy();
      clear_run(); pulse_start();
      drive(3, 1, 0, 5, 30);
      checks++;
      if (xq.size() != 16 || xq[0] !== W'(1) || xq[7] !== W'(8) || xrun[0] !== 8'd0 || xrun[8] !== 8'd1) begin
         errors++; $display("FAIL start_while_busy: %0d transfers, frame/run sequence altered, expected 16 with 1..8 in run 0", xq.size());
      end
      check_queues("start_busy");
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         clear_run(); pulse_start();
         drive(0, 2, 1, -1, -1);
         check_queues("random");
      end
   endtask

   initial begin
      test_reset();
      test_frames();
      test_backpressure();
      test_start_with_strobe();
      test_mid_reset();
      test_drop_count();
      test_start_while_busy();
      test_random();
      repeat (3) cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
